// File: rtl/memory_subsystem.sv
// memory_subsystem
//
// Memory-side responder for a single-cycle core. It holds an instruction
// memory and a data memory. After reset the block works in three phases:
//   CLEAR : one pass over both memories, writing NOP_WORD into instruction
//           words and zero into data words, one address per cycle.
//   LOAD  : accepts a program image over a valid/ready stream into
//           instruction memory, starting at word 0. The core stays in reset.
//   RUN   : the core is released from reset. It gets zero-latency
//           instruction fetches and data loads, plus clocked data stores.
//
// Ports
//   clk          in   single clock, rising edge
//   rst          in   asynchronous active-high reset (forces CLEAR)
//   ld_valid     in   load-stream word valid
//   ld_ready     out  a load word is accepted this cycle (registered, LOAD only)
//   ld_data      in   program word
//   ld_last      in   marks the final program word
//   core_rst     out  high holds the core in reset (registered, low in RUN)
//   i_mem_addr   in   fetch word address
//   i_mem_data   out  fetched instruction (NOP_WORD outside RUN)
//   d_mem_we     in   store strobe (honoured in RUN only)
//   d_mem_addr   in   data word address
//   d_mem_data   io   shared data bus. The block drives it only for RUN reads.
//
// Optional feature (macro LOAD_CHECKSUM_EN)
//   Adds output ld_checksum: the sum, modulo 2^INSTRUCTION_SIZE, of all
//   accepted load words. It resets to 0, is cleared during CLEAR and holds
//   its value in RUN.
module memory_subsystem #(
    parameter int I_ADDR_BITS      = 6,
    parameter int D_ADDR_BITS      = 6,
    parameter int WORDSIZE         = 64,
    parameter int INSTRUCTION_SIZE = 32,
    parameter logic [INSTRUCTION_SIZE-1:0] NOP_WORD = 32'h00000013
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        ld_valid,
    output logic                        ld_ready,
    input  logic [INSTRUCTION_SIZE-1:0] ld_data,
    input  logic                        ld_last,
    output logic                        core_rst,
    input  logic [I_ADDR_BITS-1:0]      i_mem_addr,
    output logic [INSTRUCTION_SIZE-1:0] i_mem_data,
    input  logic                        d_mem_we,
    input  logic [D_ADDR_BITS-1:0]      d_mem_addr,
    inout  wire  [WORDSIZE-1:0]         d_mem_data
`ifdef LOAD_CHECKSUM_EN
    ,
    output logic [INSTRUCTION_SIZE-1:0] ld_checksum
`endif
);

    // The clear pass covers the larger of the two memories.
    localparam int MAXB    = (I_ADDR_BITS > D_ADDR_BITS) ? I_ADDR_BITS : D_ADDR_BITS;
    localparam int I_DEPTH = 1 << I_ADDR_BITS;
    localparam int D_DEPTH = 1 << D_ADDR_BITS;

    typedef enum logic [1:0] {
        CLEAR = 2'd0,
        LOAD  = 2'd1,
        RUN   = 2'd2
    } state_e;

    state_e                   state_q, state_d;
    logic [MAXB-1:0]          clr_cnt_q, clr_cnt_d;
    logic [I_ADDR_BITS-1:0]   ld_ptr_q, ld_ptr_d;
    logic                     core_rst_q, core_rst_d;
    logic                     ld_ready_q, ld_ready_d;

    logic [INSTRUCTION_SIZE-1:0] imem [I_DEPTH];
    logic [WORDSIZE-1:0]         dmem [D_DEPTH];

    logic ld_fire;
    logic ld_at_end;
    logic clr_hit_i;
    logic clr_hit_d;
    logic d_store;
    logic d_drive;

    // ld_ready_q is high exactly while in LOAD, so it qualifies a transfer.
    assign ld_fire   = ld_ready_q && ld_valid;
    assign ld_at_end = (ld_ptr_q == {I_ADDR_BITS{1'b1}});

    // The clear counter may run past the smaller memory. Those cycles write nothing there.
    assign clr_hit_i = (32'(clr_cnt_q) < I_DEPTH);
    assign clr_hit_d = (32'(clr_cnt_q) < D_DEPTH);

    assign d_store = (state_q == RUN) && d_mem_we;
    assign d_drive = (state_q == RUN) && !d_mem_we;

    //------------------------------------------------------------------
    // Next-state logic
    //------------------------------------------------------------------
    always_comb begin
        state_d   = state_q;
        clr_cnt_d = clr_cnt_q;
        ld_ptr_d  = ld_ptr_q;

        case (state_q)
            CLEAR: begin
                clr_cnt_d = clr_cnt_q + 1'b1;
                if (clr_cnt_q == {MAXB{1'b1}}) begin
                    state_d = LOAD;
                end
            end
            LOAD: begin
                if (ld_fire) begin
                    // Either a marked last word or the final slot ends the load.
                    // The pointer is not advanced then, so it never wraps.
                    if (ld_last || ld_at_end) begin
                        state_d = RUN;
                    end else begin
                        ld_ptr_d = ld_ptr_q + 1'b1;
                    end
                end
            end
            RUN: begin
                state_d = RUN;
            end
            default: begin
                state_d = CLEAR;
            end
        endcase

        // Handshake outputs are registered from the next state. They change
        // on the same edge as the state.
        core_rst_d = (state_d != RUN);
        ld_ready_d = (state_d == LOAD);
    end

    //------------------------------------------------------------------
    // Control registers
    //------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= CLEAR;
            clr_cnt_q  <= '0;
            ld_ptr_q   <= '0;
            core_rst_q <= 1'b1;
            ld_ready_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            clr_cnt_q  <= clr_cnt_d;
            ld_ptr_q   <= ld_ptr_d;
            core_rst_q <= core_rst_d;
            ld_ready_q <= ld_ready_d;
        end
    end

    assign core_rst = core_rst_q;
    assign ld_ready = ld_ready_q;

    //------------------------------------------------------------------
    // Memory arrays (no reset; contents are established by the CLEAR pass)
    //------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (state_q == CLEAR) begin
            if (clr_hit_i) begin
                imem[clr_cnt_q[I_ADDR_BITS-1:0]] <= NOP_WORD;
            end
            if (clr_hit_d) begin
                dmem[clr_cnt_q[D_ADDR_BITS-1:0]] <= '0;
            end
        end else if (ld_fire) begin
            imem[ld_ptr_q] <= ld_data;
        end

        // Stores sample whatever the core puts on the released bus.
        if (d_store) begin
            dmem[d_mem_addr] <= d_mem_data;
        end
    end

    // Zero-latency reads for the single-cycle core.
    assign i_mem_data = (state_q == RUN) ? imem[i_mem_addr] : NOP_WORD;
    assign d_mem_data = d_drive ? dmem[d_mem_addr] : {WORDSIZE{1'bz}};

`ifdef LOAD_CHECKSUM_EN
    //------------------------------------------------------------------
    // Load checksum
    //------------------------------------------------------------------
    logic [INSTRUCTION_SIZE-1:0] csum_q, csum_d;

    always_comb begin
        csum_d = csum_q;
        if (state_q == CLEAR) begin
            csum_d = '0;
        end else if (ld_fire) begin
            csum_d = csum_q + ld_data;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            csum_q <= '0;
        end else begin
            csum_q <= csum_d;
        end
    end

    assign ld_checksum = csum_q;
`endif

endmodule

// File: tb/tb_memory_subsystem.sv
// Self-checking bench for memory_subsystem (default parameters). It also
// exercises ld_checksum when LOAD_CHECKSUM_EN is defined.
module tb_memory_subsystem;

    localparam logic [31:0] NOP = 32'h00000013;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        ld_valid = 1'b0;
    logic        ld_ready;
    logic [31:0] ld_data = '0;
    logic        ld_last = 1'b0;
    logic        core_rst;
    logic [5:0]  i_mem_addr = '0;
    logic [31:0] i_mem_data;
    logic        d_mem_we = 1'b0;
    logic [5:0]  d_mem_addr = '0;
    wire  [63:0] d_bus;
    logic [63:0] drv_val = '0;
    logic        drv_en = 1'b0;
`ifdef LOAD_CHECKSUM_EN
    logic [31:0] ld_checksum;
`endif

    assign d_bus = drv_en ? drv_val : {64{1'bz}};

    memory_subsystem dut (
        .clk        (clk),
        .rst        (rst),
        .ld_valid   (ld_valid),
        .ld_ready   (ld_ready),
        .ld_data    (ld_data),
        .ld_last    (ld_last),
        .core_rst   (core_rst),
        .i_mem_addr (i_mem_addr),
        .i_mem_data (i_mem_data),
        .d_mem_we   (d_mem_we),
        .d_mem_addr (d_mem_addr),
        .d_mem_data (d_bus)
`ifdef LOAD_CHECKSUM_EN
        ,
        .ld_checksum(ld_checksum)
`endif
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    // Behavioural reference: memory images and the running load sum.
    logic [31:0] ref_imem [64];
    logic [63:0] ref_dmem [64];
    logic [31:0] ref_sum;
    int          ref_ptr;

    typedef struct {
        logic [5:0]  a;
        logic [31:0] exp;
    } fvec_t;

    typedef struct {
        bit          we;
        logic [5:0]  addr;
        bit          drv;
        logic [63:0] val;
        bit          rel;   // expect the bus released by the block
        logic [63:0] exp;
    } dvec_t;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic check_released(input string name);
        total++;
        if (!(d_bus === 64'h0 || $isunknown(d_bus))) begin
            bad++;
            $display("FAIL %s: bus driven with %h expected released", name, d_bus);
        end
    endtask

    task automatic check_sum(input string name);
`ifdef LOAD_CHECKSUM_EN
        check(name, {32'h0, ld_checksum}, {32'h0, ref_sum});
`else
        ref_sum = ref_sum;
`endif
    endtask

    task automatic model_reset();
        for (int i = 0; i < 64; i++) begin
            ref_imem[i] = NOP;
            ref_dmem[i] = '0;
        end
        ref_sum = '0;
        ref_ptr = 0;
    endtask

    task automatic idle_inputs();
        ld_valid = 1'b0;
        ld_last  = 1'b0;
        d_mem_we = 1'b0;
        drv_en   = 1'b0;
    endtask

    // Enter with a negedge just passed. Leaves rst low at a negedge.
    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        idle_inputs();
        @(negedge clk);
        i_mem_addr = 6'd0;
        #1;
        check("rst_core_rst", core_rst, 1);
        check("rst_ld_ready", ld_ready, 0);
        check("rst_fetch_nop", i_mem_data, NOP);
        check_released("rst_bus");
        check_sum("rst_checksum");
        @(negedge clk);
        rst = 1'b0;
        model_reset();
    endtask

    // Counts cycles until ld_ready rises. Optionally ld_valid is held high meanwhile.
    task automatic wait_clear(input bit hold_valid);
        int n = 0;
        bit cr_ok = 1'b1;
        ld_valid = hold_valid;
        ld_data  = 32'hBADBAD00;
        while (ld_ready !== 1'b1 && n < 300) begin
            @(negedge clk);
            n++;
            if (ld_ready !== 1'b1 && core_rst !== 1'b1) cr_ok = 1'b0;
        end
        ld_valid = 1'b0;
        check("clear_cycles", n, 64);
        check("clear_core_rst_held", cr_ok, 1);
        check("clear_then_ready", ld_ready, 1);
        check("load_core_rst", core_rst, 1);
    endtask

    task automatic load_word(input logic [31:0] data, input bit last);
        check("ld_ready_for_word", ld_ready, 1);
        ld_valid = 1'b1;
        ld_data  = data;
        ld_last  = last;
        @(posedge clk);
        #1;
        ld_valid = 1'b0;
        ld_last  = 1'b0;
        ref_imem[ref_ptr] = data;
        ref_ptr++;
        ref_sum = ref_sum + data;
        @(negedge clk);
    endtask

    task automatic idle_cycle();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic fetch(input string name, input logic [5:0] a, input logic [31:0] exp);
        i_mem_addr = a;
        #1;
        check(name, i_mem_data, exp);
    endtask

    task automatic check_run(input string name);
        check({name, "_core_rst"}, core_rst, 0);
        check({name, "_ld_ready"}, ld_ready, 0);
    endtask

    fvec_t fv[6];
    dvec_t dv[9];

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        // ---------------- reset, clear with ld_valid held ----------------
        do_reset();
        i_mem_addr = 6'd0;
        wait_clear(1'b1);
        fetch("load_fetch_nop", 6'd0, NOP);
        check_released("load_bus");

        // ---------------- three-word program with an idle gap ----------------
        load_word(32'h00500093, 1'b0);
        idle_cycle();
        check("gap_still_load", ld_ready, 1);
        load_word(32'h00108113, 1'b0);
        load_word(32'h00000013, 1'b1);
        check_run("prog3");
        check_sum("prog3_checksum");
        check("prog3_sum_value", ref_sum, 32'h006081B9);

        fv[0] = '{6'd1,  32'h00108113};
        fv[1] = '{6'd5,  32'h00000013};
        fv[2] = '{6'd0,  32'h00500093};
        fv[3] = '{6'd2,  32'h00000013};
        fv[4] = '{6'd63, 32'h00000013};
        fv[5] = '{6'd3,  32'h00000013};
        for (int i = 0; i < 6; i++) begin
            fetch($sformatf("prog3_fetch%0d", i), fv[i].a, fv[i].exp);
        end

        // ---------------- data bus table ----------------
        dv[0] = '{1'b0, 6'd3, 1'b0, 64'h0,                 1'b0, 64'h0};
        dv[1] = '{1'b1, 6'd3, 1'b1, 64'hDEADBEEFCAFEF00D, 1'b0, 64'hDEADBEEFCAFEF00D};
        dv[2] = '{1'b0, 6'd3, 1'b0, 64'h0,                 1'b0, 64'hDEADBEEFCAFEF00D};
        dv[3] = '{1'b0, 6'd4, 1'b0, 64'h0,                 1'b0, 64'h0};
        dv[4] = '{1'b1, 6'd3, 1'b1, 64'h0123456789ABCDEF, 1'b0, 64'h0123456789ABCDEF};
        dv[5] = '{1'b0, 6'd3, 1'b0, 64'h0,                 1'b0, 64'h0123456789ABCDEF};
        dv[6] = '{1'b1, 6'd9, 1'b1, 64'h5555AAAA5555AAAA, 1'b0, 64'h5555AAAA5555AAAA};
        dv[7] = '{1'b0, 6'd9, 1'b0, 64'h0,                 1'b0, 64'h5555AAAA5555AAAA};
        dv[8] = '{1'b1, 6'd9, 1'b0, 64'h0,                 1'b1, 64'h0};
        for (int i = 0; i < 9; i++) begin
            d_mem_we   = dv[i].we;
            d_mem_addr = dv[i].addr;
            drv_en     = dv[i].drv;
            drv_val    = dv[i].val;
            #1;
            if (dv[i].rel) check_released($sformatf("dtab%0d_released", i));
            else           check($sformatf("dtab%0d_bus", i), d_bus, dv[i].exp);
            @(posedge clk);
            #1;
            d_mem_we = 1'b0;
            drv_en   = 1'b0;
            @(negedge clk);
        end

        // ---------------- load stream ignored in RUN ----------------
        ld_valid = 1'b1;
        ld_data  = 32'hFFFFFFFF;
        ld_last  = 1'b1;
        idle_cycle();
        idle_cycle();
        idle_inputs();
        check_run("run_ignore");
        fetch("run_ignore_fetch3", 6'd3, NOP);
        fetch("run_ignore_fetch0", 6'd0, 32'h00500093);
        check_sum("run_ignore_checksum");

        // ---------------- full 64-word stream without ld_last ----------------
        do_reset();
        wait_clear(1'b0);
        for (int n = 0; n < 64; n++) begin
            load_word(32'h1000 + n, 1'b0);
            if (n == 62) check("stream63_still_load", ld_ready, 1);
        end
        check_run("stream64");
        fetch("stream64_fetch63", 6'd63, 32'h0000103F);
        fetch("stream64_fetch0", 6'd0, 32'h00001000);
        fetch("stream64_fetch31", 6'd31, 32'h0000101F);
        check_sum("stream64_checksum");
        check("stream64_sum_value", ref_sum, 32'h000407E0);
        // leave a nonzero data word behind for the re-clear check
        d_mem_we = 1'b1; d_mem_addr = 6'd10; drv_en = 1'b1; drv_val = 64'hCAFE0000BEEF1111;
        @(posedge clk); #1; d_mem_we = 1'b0; drv_en = 1'b0;
        @(negedge clk);
        d_mem_addr = 6'd10;
        #1;
        check("stream64_store10", d_bus, 64'hCAFE0000BEEF1111);
        // the block must let go of the bus on a store even with nobody driving
        d_mem_we = 1'b1;
        #1;
        check_released("run_store_undriven");
        d_mem_we   = 1'b0;
        d_mem_addr = 6'd0;
        @(negedge clk);

        // ---------------- reset mid-LOAD ----------------
        do_reset();
        wait_clear(1'b0);
        d_mem_we = 1'b1; d_mem_addr = 6'd7; drv_en = 1'b1; drv_val = 64'hFFFFFFFFFFFFFFFF;
        #1;
        check("load_store_bus", d_bus, 64'hFFFFFFFFFFFFFFFF);
        @(posedge clk); #1; d_mem_we = 1'b0; drv_en = 1'b0;
        @(negedge clk);
        load_word(32'hAAAA0001, 1'b0);
        load_word(32'hAAAA0002, 1'b0);
        #2;
        rst = 1'b1;
        #1;
        check("async_rst_core_rst", core_rst, 1);
        check("async_rst_ld_ready", ld_ready, 0);
        @(negedge clk);
        rst = 1'b0;
        model_reset();
        wait_clear(1'b0);
        load_word(32'h12345678, 1'b1);
        check_run("reload");
        fetch("reload_fetch1", 6'd1, NOP);
        fetch("reload_fetch0", 6'd0, 32'h12345678);
        check_sum("reload_checksum");
        begin
            int nz = 0;
            for (int a = 0; a < 64; a++) begin
                d_mem_addr = a[5:0];
                #1;
                if (d_bus !== 64'h0) nz++;
            end
            check("reload_dmem_all_zero", nz, 0);
        end
        d_mem_addr = 6'd7;
        #1;
        check("reload_dmem7", d_bus, 64'h0);
        d_mem_addr = 6'd10;
        #1;
        check("reload_dmem10", d_bus, 64'h0);
        @(negedge clk);

        // ---------------- randomized program and traffic ----------------
        for (int pass = 0; pass < 3; pass++) begin
            int len;
            do_reset();
            wait_clear(1'b0);
            len = $urandom_range(1, 64);
            for (int i = 0; i < len; i++) begin
                int gap = $urandom_range(0, 2);
                for (int g = 0; g < gap; g++) idle_cycle();
                load_word($urandom, (i == len - 1) ? ((len < 64) ? 1'b1 : 1'($urandom_range(0, 1))) : 1'b0);
            end
            check_run($sformatf("rand%0d", pass));
            check_sum($sformatf("rand%0d_checksum", pass));
            for (int k = 0; k < 150; k++) begin
                logic [5:0]  fa;
                logic [5:0]  da;
                logic [63:0] wv;
                int op;
                fa = 6'($urandom_range(0, 63));
                da = 6'($urandom_range(0, 63));
                wv = {$urandom, $urandom};
                op = $urandom_range(0, 1);
                i_mem_addr = fa;
                d_mem_addr = da;
                d_mem_we   = (op == 1);
                drv_en     = (op == 1);
                drv_val    = wv;
                #1;
                check($sformatf("rand%0d_fetch%0d", pass, k), i_mem_data, ref_imem[fa]);
                if (op == 1) check($sformatf("rand%0d_wbus%0d", pass, k), d_bus, wv);
                else         check($sformatf("rand%0d_read%0d", pass, k), d_bus, ref_dmem[da]);
                @(posedge clk);
                #1;
                if (op == 1) ref_dmem[da] = wv;
                d_mem_we = 1'b0;
                drv_en   = 1'b0;
                @(negedge clk);
            end
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
